// File: rtl/mem_arbiter_multiport_pkg.sv
// Shared types, exception codes and helpers for the multi-port word memory.
// Size encodings, exception codes and the registered response record.
package mem_arbiter_multiport_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_WORD     = 2'd2,
        SZ_WORD_ALT = 2'd3
    } mem_size_e;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    typedef struct packed {
        logic [31:0] data;
        logic        exc_valid;
        logic [3:0]  exc_code;
    } mem_resp_t;

    function automatic logic [3:0] exc_code(input logic is_store, input logic misalign);
        if (is_store)
            exc_code = misalign ? EXC_ST_MISALIGN : EXC_ST_FAULT;
        else
            exc_code = misalign ? EXC_LD_MISALIGN : EXC_LD_FAULT;
    endfunction

    function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << off;
            SZ_HALF: byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_multiport_if.sv
// Bundled request/response bus of all requester channels, flattened per channel.
interface mem_arbiter_multiport_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_write;
    logic [NUM_CH*2-1:0]      req_size;
    logic [NUM_CH-1:0]        req_lr;
    logic [NUM_CH-1:0]        req_sc;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*32-1:0]     req_data;
    logic [NUM_CH-1:0]        resp_valid;
    logic [NUM_CH*32-1:0]     resp_data;
    logic [NUM_CH-1:0]        resp_exc_valid;
    logic [NUM_CH*4-1:0]      resp_exc_code;

    modport master (
        output req_valid, req_write, req_size, req_lr, req_sc, req_addr, req_data,
        input  req_ready, resp_valid, resp_data, resp_exc_valid, resp_exc_code
    );

    modport slave (
        input  req_valid, req_write, req_size, req_lr, req_sc, req_addr, req_data,
        output req_ready, resp_valid, resp_data, resp_exc_valid, resp_exc_code
    );
endinterface

// File: rtl/mem_arbiter_multiport_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts one past the last winner.
module mem_arbiter_multiport_rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;
    logic [N-1:0]     w_gnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    always_comb begin
        w_gnt  = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = (IDX_W+1)'(r_ptr) + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(N))
                w_cand = w_cand - (IDX_W+1)'(N);
            if (!w_any && i_req[w_cand[IDX_W-1:0]]) begin
                w_any                     = 1'b1;
                w_idx                     = w_cand[IDX_W-1:0];
                w_gnt[w_cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ptr <= IDX_W'(N-1);
        else if (w_any)
            r_ptr <= w_idx;
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_any = w_any;
endmodule

// File: rtl/mem_arbiter_multiport.sv
// Shared word memory for NUM_CH requesters: round-robin grant, size/alignment/range
// checks, byte-lane stores, per-channel LR/SC reservations and a one-cycle response.
module mem_arbiter_multiport
    import mem_arbiter_multiport_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input logic                     clk,
    input logic                     reset,
    mem_arbiter_multiport_if.slave  bus
);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WIDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [1:0]        w_size_a [NUM_CH];
    logic [ADDR_W-1:0] w_addr_a [NUM_CH];
    logic [31:0]       w_data_a [NUM_CH];

    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_ch;
    logic              w_any;
    logic              w_go;

    logic              w_write, w_word, w_misalign, w_fault, w_exc;
    logic              w_is_lr, w_is_sc, w_sc_ok, w_do_write;
    mem_size_e         w_size;
    logic [ADDR_W-1:0] w_addr, w_off_addr;
    logic [WIDX_W-1:0] w_widx;
    logic [31:0]       w_wd, w_wdata;
    logic [3:0]        w_be;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       r_rdata;

    logic [NUM_CH-1:0] r_res_valid;
    logic [WIDX_W-1:0] r_res_addr [NUM_CH];

    logic              r_valid, r_exc, r_load, r_sc_fail;
    logic [IDX_W-1:0]  r_ch;
    logic [3:0]        r_code;
    mem_size_e         r_size;
    logic [1:0]        r_off;
    logic [31:0]       w_shift, w_ld;
    mem_resp_t         w_resp;

    always_ff @(posedge clk) begin
        assert (DATA_W == 32);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_size_a[gi] = bus.req_size[gi*2 +: 2];
        assign w_addr_a[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign w_data_a[gi] = bus.req_data[gi*32 +: 32];
    end

    mem_arbiter_multiport_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req (bus.req_valid),
        .o_gnt (w_gnt),
        .o_idx (w_ch),
        .o_any (w_any)
    );

    // No grants are handed out while reset is held.
    assign bus.req_ready = w_gnt & {NUM_CH{reset}};
    assign w_go          = w_any & reset;

    always_comb begin
        w_write    = bus.req_write[w_ch];
        w_size     = mem_size_e'(w_size_a[w_ch]);
        w_addr     = w_addr_a[w_ch];
        w_wd       = w_data_a[w_ch];
        w_word     = (w_size == SZ_WORD) || (w_size == SZ_WORD_ALT);
        w_misalign = ((w_size == SZ_HALF) && w_addr[0]) || (w_word && (w_addr[1:0] != 2'b00));
        w_off_addr = w_addr - BASE;
        w_fault    = (w_addr < BASE) || (w_off_addr[ADDR_W-1:WIDX_W+2] != '0);
        w_exc      = w_misalign || w_fault;
        w_widx     = w_off_addr[WIDX_W+1:2];
        w_is_lr    = !w_write && w_word && bus.req_lr[w_ch];
        w_is_sc    = w_write && w_word && bus.req_sc[w_ch];
        w_sc_ok    = r_res_valid[w_ch] && (r_res_addr[w_ch] == w_widx);
        w_do_write = w_go && w_write && !w_exc && (!w_is_sc || w_sc_ok);
        w_be       = byte_en(w_size, w_off_addr[1:0]);
        w_wdata    = w_wd << {w_off_addr[1:0], 3'b000};
    end

    // Storage is not reset; the read port is registered so a store lands before the next load.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    mem[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
        if (w_go && !w_write)
            r_rdata <= mem[w_widx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_valid <= '0;
            for (int i = 0; i < NUM_CH; i++)
                r_res_addr[i] <= '0;
        end else if (w_go && !w_exc) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch == IDX_W'(i)) begin
                    if (w_is_lr) begin
                        r_res_valid[i] <= 1'b1;
                        r_res_addr[i]  <= w_widx;
                    end else if (w_is_sc) begin
                        r_res_valid[i] <= 1'b0;
                    end
                end else if (w_do_write && (r_res_addr[i] == w_widx)) begin
                    r_res_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_ch      <= '0;
            r_exc     <= 1'b0;
            r_code    <= '0;
            r_load    <= 1'b0;
            r_sc_fail <= 1'b0;
            r_size    <= SZ_BYTE;
            r_off     <= '0;
        end else begin
            r_valid <= w_go;
            if (w_go) begin
                r_ch      <= w_ch;
                r_exc     <= w_exc;
                r_code    <= exc_code(w_write, w_misalign);
                r_load    <= !w_write && !w_exc;
                r_sc_fail <= w_is_sc && !w_exc && !w_sc_ok;
                r_size    <= w_size;
                r_off     <= w_off_addr[1:0];
            end
        end
    end

    always_comb begin
        w_shift = r_rdata >> {r_off, 3'b000};
        case (r_size)
            SZ_BYTE: w_ld = {24'h0, w_shift[7:0]};
            SZ_HALF: w_ld = {16'h0, w_shift[15:0]};
            default: w_ld = w_shift;
        endcase
        w_resp.data      = r_load ? w_ld : {31'h0, r_sc_fail};
        w_resp.exc_valid = r_exc;
        w_resp.exc_code  = r_exc ? r_code : 4'h0;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_resp
        logic w_sel;
        assign w_sel                         = r_valid && (r_ch == IDX_W'(gi));
        assign bus.resp_valid[gi]            = w_sel;
        assign bus.resp_data[gi*32 +: 32]    = w_sel ? w_resp.data : 32'h0;
        assign bus.resp_exc_valid[gi]        = w_sel && w_resp.exc_valid;
        assign bus.resp_exc_code[gi*4 +: 4]  = w_sel ? w_resp.exc_code : 4'h0;
    end
endmodule

// File: tb/tb_mem_arbiter_multiport.sv
// Bench for mem_arbiter_multiport: directed scenarios plus random traffic against a
// byte-addressed reference memory with per-channel reservations.
`timescale 1ns/1ps
module tb_mem_arbiter_multiport;
    localparam int NUM_CH      = 2;
    localparam int ADDR_W      = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_multiport_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus();

    mem_arbiter_multiport #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(32),
        .DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mref [int];
    bit         mres_v [NUM_CH];
    int         mres_w [NUM_CH];
    int         m_ptr;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) mres_v[c] = 1'b0;
        m_ptr = NUM_CH - 1;
    endtask

    task automatic model_exec(input int ch, input bit we, input int sz, input bit lr, input bit sc,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] ed, output bit eex, output logic [3:0] ecode);
        int nb; longint off; int w; bit ok;
        nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        ed = '0; eex = 1'b0; ecode = '0;
        off = longint'(addr) - longint'(BASE);
        if ((addr % nb) != 0) begin eex = 1'b1; ecode = we ? 4'd6 : 4'd4; return; end
        if (off < 0 || off >= longint'(DEPTH_WORDS) * 4) begin eex = 1'b1; ecode = we ? 4'd7 : 4'd5; return; end
        w = int'(off / 4);
        if (we) begin
            if (sc && nb == 4) begin
                ok = mres_v[ch] && (mres_w[ch] == w);
                mres_v[ch] = 1'b0;
                ed = ok ? 32'd0 : 32'd1;
                if (!ok) return;
            end
            for (int b = 0; b < nb; b++) mref[int'(off) + b] = wd[8*b +: 8];
            for (int c = 0; c < NUM_CH; c++)
                if (c != ch && mres_v[c] && mres_w[c] == w) mres_v[c] = 1'b0;
        end else begin
            for (int b = 0; b < nb; b++) ed[8*b +: 8] = mref[int'(off) + b];
            if (lr && nb == 4) begin mres_v[ch] = 1'b1; mres_w[ch] = w; end
        end
    endtask

    task automatic clear_req();
        bus.req_valid = '0; bus.req_write = '0; bus.req_size = '0;
        bus.req_lr = '0; bus.req_sc = '0; bus.req_addr = '0; bus.req_data = '0;
    endtask

    task automatic set_req(input int ch, input bit we, input int sz, input bit lr, input bit sc,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.req_write[ch]          = we;
        bus.req_size[ch*2 +: 2]    = 2'(sz);
        bus.req_lr[ch]             = lr;
        bus.req_sc[ch]             = sc;
        bus.req_addr[ch*32 +: 32]  = addr;
        bus.req_data[ch*32 +: 32]  = wd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_req();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Drives one request on one channel, waits (bounded) for its grant and samples the response.
    task automatic do_req(input int ch, input bit we, input int sz, input bit lr, input bit sc,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output bit rv, output logic [31:0] rd, output bit rex, output logic [3:0] rcode);
        int cnt;
        rv = 1'b0; rd = '0; rex = 1'b0; rcode = '0;
        @(negedge clk);
        set_req(ch, we, sz, lr, sc, addr, wd);
        bus.req_valid[ch] = 1'b1;
        #1;
        cnt = 0;
        while (bus.req_ready[ch] !== 1'b1 && cnt < 20) begin
            @(negedge clk); #1; cnt++;
        end
        if (cnt >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout ch%0d ready=%b required grant within 20 cycles", ch, bus.req_ready);
            bus.req_valid[ch] = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid[ch] = 1'b0;
        rv    = bus.resp_valid[ch];
        rd    = bus.resp_data[ch*32 +: 32];
        rex   = bus.resp_exc_valid[ch];
        rcode = bus.resp_exc_code[ch*4 +: 4];
        $display("txn ch%0d we=%0d sz=%0d lr=%0d sc=%0d addr=%h wdata=%h -> v=%0d data=%h exc=%0d code=%0d",
                 ch, we, sz, lr, sc, addr, wd, rv, rd, rex, rcode);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_req();
        bus.req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== '0 || bus.resp_exc_valid !== '0 || bus.resp_exc_code !== '0) begin
            n_fail++; $display("FAIL reset_resp_fields data=%h exc=%b code=%h exp=0", bus.resp_data, bus.resp_exc_valid, bus.resp_exc_code);
        end
        clear_req();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        bit v, ex; logic [31:0] d, ed; logic [3:0] c, ec; bit eex;
        model_exec(0, 1, 2, 0, 0, 32'h10, 32'hDEADBEEF, ed, eex, ec);
        do_req(0, 1, 2, 0, 0, 32'h10, 32'hDEADBEEF, v, d, ex, c);
        n_checks++; if (v !== 1'b1 || ex !== 1'b0) begin n_fail++; $display("FAIL basic_store v=%0d exc=%0d exp v=1 exc=0", v, ex); end
        model_exec(0, 0, 2, 0, 0, 32'h10, 32'h0, ed, eex, ec);
        do_req(0, 0, 2, 0, 0, 32'h10, 32'h0, v, d, ex, c);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL basic_load_valid got=%0d exp=1", v); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_load_data got=%h exp=deadbeef", d); end
        n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL basic_load_exc got=%0d exp=0", ex); end
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL basic_pulse_width resp_valid=%b exp=0", bus.resp_valid); end
    endtask

    task automatic test_rr();
        logic [NUM_CH-1:0] exp_g, prev_g;
        int c;
        apply_reset();
        @(negedge clk);
        for (int ch = 0; ch < NUM_CH; ch++) set_req(ch, 0, 2, 0, 0, 32'h10, 32'h0);
        bus.req_valid = '1;
        prev_g = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_g = '0;
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (m_ptr + i) % NUM_CH;
                if (exp_g == '0 && bus.req_valid[c]) begin exp_g[c] = 1'b1; m_ptr = c; end
            end
            n_checks++; if (bus.req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant cycle%0d got=%b exp=%b", k, bus.req_ready, exp_g); end
            n_checks++; if (bus.resp_valid !== prev_g) begin n_fail++; $display("FAIL rr_resp cycle%0d got=%b exp=%b", k, bus.resp_valid, prev_g); end
            $display("txn rr cycle%0d grant=%b resp_valid=%b", k, bus.req_ready, bus.resp_valid);
            prev_g = exp_g;
            @(negedge clk);
        end
        bus.req_valid = '0;
        #1;
        n_checks++; if (bus.resp_valid !== prev_g) begin n_fail++; $display("FAIL rr_last_resp got=%b exp=%b", bus.resp_valid, prev_g); end
        n_checks++; if (bus.resp_data !== {NUM_CH{32'hDEADBEEF}} & {{32{prev_g[1]}}, {32{prev_g[0]}}}) begin
            n_fail++; $display("FAIL rr_last_data got=%h", bus.resp_data);
        end
    endtask

    task automatic test_exceptions();
        bit v, ex, eex; logic [31:0] d, ed; logic [3:0] c, ec;
        do_req(0, 0, 1, 0, 0, 32'h11, 32'h0, v, d, ex, c);
        n_checks++; if (v !== 1'b1 || ex !== 1'b1 || c !== 4'd4 || d !== 32'h0) begin
            n_fail++; $display("FAIL exc_ld_misalign v=%0d exc=%0d code=%0d data=%h exp 1/1/4/0", v, ex, c, d);
        end
        model_exec(0, 1, 2, 0, 0, 32'h0, 32'h55AA1234, ed, eex, ec);
        do_req(0, 1, 2, 0, 0, 32'h0, 32'h55AA1234, v, d, ex, c);
        do_req(1, 1, 2, 0, 0, DEPTH_WORDS * 4, 32'hFFFFFFFF, v, d, ex, c);
        n_checks++; if (ex !== 1'b1 || c !== 4'd7) begin n_fail++; $display("FAIL exc_st_fault exc=%0d code=%0d exp 1/7", ex, c); end
        do_req(1, 1, 2, 0, 0, 32'h2, 32'hFFFFFFFF, v, d, ex, c);
        n_checks++; if (ex !== 1'b1 || c !== 4'd6) begin n_fail++; $display("FAIL exc_st_misalign exc=%0d code=%0d exp 1/6", ex, c); end
        do_req(0, 0, 2, 0, 0, 32'h0, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'h55AA1234 || ex !== 1'b0) begin n_fail++; $display("FAIL exc_mem_unchanged got=%h exp=55aa1234", d); end
        do_req(0, 0, 2, 0, 0, 32'hFFFFFFFC, 32'h0, v, d, ex, c);
        n_checks++; if (ex !== 1'b1 || c !== 4'd5 || d !== 32'h0) begin n_fail++; $display("FAIL exc_ld_fault exc=%0d code=%0d data=%h exp 1/5/0", ex, c, d); end
    endtask

    task automatic test_byte_lanes();
        bit v, ex, eex; logic [31:0] d, ed; logic [3:0] c, ec;
        model_exec(0, 1, 2, 0, 0, 32'h10, 32'h11223344, ed, eex, ec);
        do_req(0, 1, 2, 0, 0, 32'h10, 32'h11223344, v, d, ex, c);
        model_exec(1, 1, 0, 0, 0, 32'h13, 32'h000000AA, ed, eex, ec);
        do_req(1, 1, 0, 0, 0, 32'h13, 32'h000000AA, v, d, ex, c);
        do_req(0, 0, 2, 0, 0, 32'h10, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'hAA223344) begin n_fail++; $display("FAIL lanes_word got=%h exp=aa223344", d); end
        do_req(0, 0, 0, 0, 0, 32'h13, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'h000000AA) begin n_fail++; $display("FAIL lanes_byte got=%h exp=000000aa", d); end
        do_req(1, 0, 1, 0, 0, 32'h12, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'h0000AA22) begin n_fail++; $display("FAIL lanes_half got=%h exp=0000aa22", d); end
    endtask

    task automatic test_lrsc();
        bit v, ex, eex; logic [31:0] d, ed; logic [3:0] c, ec;
        model_exec(0, 1, 2, 0, 0, 32'h20, 32'h01020304, ed, eex, ec);
        do_req(0, 1, 2, 0, 0, 32'h20, 32'h01020304, v, d, ex, c);
        model_exec(0, 0, 2, 1, 0, 32'h20, 32'h0, ed, eex, ec);
        do_req(0, 0, 2, 1, 0, 32'h20, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'h01020304) begin n_fail++; $display("FAIL lr_data got=%h exp=01020304", d); end
        model_exec(1, 1, 2, 0, 0, 32'h20, 32'h0BADF00D, ed, eex, ec);
        do_req(1, 1, 2, 0, 0, 32'h20, 32'h0BADF00D, v, d, ex, c);
        model_exec(0, 1, 2, 0, 1, 32'h20, 32'hCAFE0001, ed, eex, ec);
        do_req(0, 1, 2, 0, 1, 32'h20, 32'hCAFE0001, v, d, ex, c);
        n_checks++; if (d !== 32'd1 || v !== 1'b1) begin n_fail++; $display("FAIL sc_killed got=%h exp=1", d); end
        do_req(0, 0, 2, 0, 0, 32'h20, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'h0BADF00D) begin n_fail++; $display("FAIL sc_killed_mem got=%h exp=0badf00d", d); end
        model_exec(0, 0, 2, 1, 0, 32'h20, 32'h0, ed, eex, ec);
        do_req(0, 0, 2, 1, 0, 32'h20, 32'h0, v, d, ex, c);
        model_exec(0, 1, 2, 0, 1, 32'h20, 32'hCAFE0002, ed, eex, ec);
        do_req(0, 1, 2, 0, 1, 32'h20, 32'hCAFE0002, v, d, ex, c);
        n_checks++; if (d !== 32'd0 || v !== 1'b1) begin n_fail++; $display("FAIL sc_ok got=%h exp=0", d); end
        do_req(1, 0, 2, 0, 0, 32'h20, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'hCAFE0002) begin n_fail++; $display("FAIL sc_ok_mem got=%h exp=cafe0002", d); end
    endtask

    task automatic test_reset_mid();
        bit v, ex, eex; logic [31:0] d, ed; logic [3:0] c, ec;
        model_exec(0, 1, 2, 0, 0, 32'h30, 32'h13572468, ed, eex, ec);
        do_req(0, 1, 2, 0, 0, 32'h30, 32'h13572468, v, d, ex, c);
        model_exec(0, 0, 2, 1, 0, 32'h30, 32'h0, ed, eex, ec);
        do_req(0, 0, 2, 1, 0, 32'h30, 32'h0, v, d, ex, c);
        @(negedge clk);
        set_req(1, 0, 2, 0, 0, 32'h30, 32'h0);
        bus.req_valid[1] = 1'b1;
        #1;
        n_checks++; if (bus.req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL midrst_grant got=%b exp ch1", bus.req_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL midrst_drop got=%b exp=0", bus.resp_valid); end
        @(negedge clk);
        bus.req_valid = '0;
        n_checks++; if (bus.resp_valid !== '0 || bus.resp_data !== '0) begin n_fail++; $display("FAIL midrst_hold v=%b d=%h exp=0", bus.resp_valid, bus.resp_data); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        model_exec(0, 1, 2, 0, 1, 32'h30, 32'h99999999, ed, eex, ec);
        do_req(0, 1, 2, 0, 1, 32'h30, 32'h99999999, v, d, ex, c);
        n_checks++; if (d !== 32'd1 || v !== 1'b1) begin n_fail++; $display("FAIL midrst_sc got=%h exp=1", d); end
        do_req(0, 0, 2, 0, 0, 32'h30, 32'h0, v, d, ex, c);
        n_checks++; if (d !== 32'h13572468) begin n_fail++; $display("FAIL midrst_mem got=%h exp=13572468", d); end
    endtask

    task automatic test_random();
        bit v, ex, eex, we, lr, sc; logic [31:0] d, ed, addr, wd; logic [3:0] c, ec;
        int ch, kind, sz;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model_exec(0, 1, 2, 0, 0, 32'h40 + 4*w, wd, ed, eex, ec);
            do_req(0, 1, 2, 0, 0, 32'h40 + 4*w, wd, v, d, ex, c);
        end
        for (int n = 0; n < 80; n++) begin
            ch   = int'($urandom_range(0, NUM_CH-1));
            kind = int'($urandom_range(0, 3));
            sz   = int'($urandom_range(0, 3));
            we = (kind == 1 || kind == 3);
            lr = (kind == 2);
            sc = (kind == 3);
            if (lr || sc) sz = 2 + int'($urandom_range(0, 1));
            addr = 32'h40 + $urandom_range(0, 63);
            if ((lr || sc) && $urandom_range(0, 3) != 0) addr = {addr[31:2], 2'b00};
            if ($urandom_range(0, 7) == 0) addr = DEPTH_WORDS * 4 + $urandom_range(0, 63);
            wd = $urandom;
            model_exec(ch, we, sz, lr, sc, addr, wd, ed, eex, ec);
            do_req(ch, we, sz, lr, sc, addr, wd, v, d, ex, c);
            n_checks++;
            if (v !== 1'b1 || ex !== eex || c !== ec || ((!we || sc || eex) && d !== ed)) begin
                n_fail++;
                $display("FAIL random_%0d ch%0d addr=%h got v=%0d d=%h exc=%0d code=%0d exp d=%h exc=%0d code=%0d",
                         n, ch, addr, v, d, ex, c, ed, eex, ec);
            end
        end
    endtask

    initial begin
        clear_req();
        model_reset();
        test_reset();
        test_basic();
        test_rr();
        test_exceptions();
        test_byte_lanes();
        test_lrsc();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
